gpr_cdb_arbiter: RTL
====================

Name: gpr_cdb_arbiter

Overview:
- Shares the single GPR common data bus (CDB) among N_REQ result producers: mov station, ALU stations, load unit, and so on.
- Each producer raises a valid/ready request. The arbiter grants exactly one per cycle with round-robin fairness.
- The granted producer registers its result on the grant edge. The arbiter muxes that result onto the CDB in the following cycle for ROB and reservation-station wakeup.

Parameters:
- N_REQ, 4, number of requesting producers (at least 2).
- ROB_WIDTH, 4, width of ROB tag.
- DATA_WIDTH, 32, width of result data.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-producer request (producer has a dispatchable result)
- req_ready  output  N_REQ  per-producer grant; one-hot or zero
- res_tag  input  N_REQ*ROB_WIDTH  producer i registered result tag, slice i
- res_data  input  N_REQ*DATA_WIDTH  producer i registered result data, slice i
- hold  input  1  bus blocked this cycle; no new grants
- cdb_valid  output  1  CDB broadcast valid
- cdb_tag  output  ROB_WIDTH  broadcast ROB tag
- cdb_data  output  DATA_WIDTH  broadcast data
- cdb_src  output  $clog2(N_REQ)  index of the broadcasting producer (debug/perf)

Behaviour:
- Clock clk; reset is synchronous, active-high.
- State:
  - rr_ptr, $clog2(N_REQ) bits
  - sel_q, $clog2(N_REQ) bits
  - valid_q, 1 bit
- Reset values: rr_ptr=0, sel_q=0, valid_q=0.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0 on the cycle after the reset edge.
  - req_ready all 0 while reset is high.
- Winner selection (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... mod N_REQ; the first i with req_valid[i]=1 wins.
  - grant = (any req_valid) && !hold && !reset.
- req_ready[winner] = grant; all other bits 0. At most one bit is ever set.
  - req_ready depends combinationally on req_valid. Producers must not derive req_valid from req_ready.
- Handshake: the transfer occurs on a rising edge where req_valid[i] && req_ready[i].
  - The producer captures tag/data into its result register on that edge and holds it stable for exactly the next cycle.
- On each edge:
  - valid_q <= grant; sel_q <= winner if grant, else unchanged.
  - rr_ptr <= (winner+1) mod N_REQ if grant, else unchanged.
- Outputs (cycle t+1 after a grant at cycle t):
  - cdb_valid = valid_q.
  - cdb_tag / cdb_data = res_tag / res_data slice sel_q when valid_q=1, else 0.
  - cdb_src = sel_q.
  - Latency is one cycle from grant to broadcast. Throughput is one broadcast per cycle with back-to-back grants.
- Wrap-around: winner N_REQ-1 sets rr_ptr=0.
- hold high:
  - No req_ready; rr_ptr is frozen.
  - The broadcast from the previous cycle's grant still completes (cdb_valid=1 that cycle).
  - The cycle after hold has cdb_valid=0.
- No requesters: no grant, rr_ptr unchanged, cdb_valid=0 next cycle.
- Simultaneous requests from all producers: served in rotating order; each waits at most N_REQ-1 grants.
- Reset mid-operation: a grant issued in the cycle before the reset edge is discarded (valid_q cleared by reset). No broadcast appears after reset.
- Assertion: $onehot0(req_ready) every cycle.

Test Plan:
- Reset, then req_valid=4'b0000 for 3 cycles -> req_ready=0, cdb_valid=0, cdb_tag=0, cdb_data=0 throughout.
- req_valid=4'b0100 at t=0, producer 2 presents tag 5 / data 0x1234 at t=1 -> req_ready=4'b0100 at t=0; cdb_valid=1, cdb_tag=5, cdb_data=0x1234, cdb_src=2 at t=1; rr_ptr=3.
- req_valid=4'b1111 held for 8 cycles from reset -> grants in order 0,1,2,3,0,1,2,3, one per cycle; cdb_valid=1 on every cycle t=1..8; cdb_src follows the same order one cycle late.
- rr_ptr=3, req_valid=4'b1001 -> grant 3, then grant 0 (wrap), then grant 3.
- Grant to producer 1 at t=0, hold=1 at t=1..2 with req_valid=4'b0011 -> broadcast from producer 1 at t=1; req_ready=0 and cdb_valid=0 at t=2; hold low at t=3 -> grant producer 0 (rr_ptr=2 wraps past 2,3).
- Grant to producer 0 at t=0, reset=1 at t=0 edge -> cdb_valid=0 at t=1, rr_ptr=0, no broadcast.

Source files
------------

// File: rtl/gpr_cdb_arbiter.sv
// Round-robin arbiter for the shared GPR common data bus: grants one producer per
// cycle and broadcasts that producer's registered result on the following cycle.
module gpr_cdb_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*ROB_WIDTH-1:0]    res_tag,
    input  logic [N_REQ*DATA_WIDTH-1:0]   res_data,
    input  logic                          hold,
    output logic                          cdb_valid,
    output logic [ROB_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    output logic [$clog2(N_REQ)-1:0]      cdb_src
);

    localparam int PTR_W = $clog2(N_REQ);

    // Handshake: producer i transfers on a rising edge where req_valid[i] && req_ready[i];
    // req_ready is a combinational function of req_valid, so req_valid must never
    // depend on req_ready. The producer then holds tag/data stable for the next cycle.

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] sel_q;
    logic             valid_q;

    logic [PTR_W-1:0] winner;
    logic             found;
    logic             grant;
    logic [PTR_W-1:0] next_ptr;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx    = 0;
        winner = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                winner = PTR_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant     = found && !hold && !reset;
        req_ready = '0;
        if (grant) begin
            req_ready = N_REQ'(1) << winner;
        end
        if (int'(winner) == N_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= grant;
            if (grant) begin
                sel_q  <= winner;
                rr_ptr <= next_ptr;
            end
        end
    end

    always_comb begin
        cdb_valid = valid_q;
        cdb_src   = sel_q;
        cdb_tag   = '0;
        cdb_data  = '0;
        if (valid_q) begin
            cdb_tag  = res_tag[int'(sel_q)*ROB_WIDTH +: ROB_WIDTH];
            cdb_data = res_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        assert ($onehot0(req_ready));
    end

endmodule
